// File: rtl/comparador_sar_pkg.sv
// Shared types and constants for the SAR conversion controller.
// The latency helper gives the edge count from start capture to the DONE state.
package comparador_sar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } sar_state_e;

    localparam int DEF_N_BITS     = 8;
    localparam int DEF_SETTLE_CYC = 2;

    // One SAMPLE edge, then SETTLE_CYC settle edges plus one DECIDE edge per bit.
    function automatic int sar_latency(input int n_bits, input int settle_cyc);
        return 1 + n_bits * (settle_cyc + 1);
    endfunction

endpackage

// File: rtl/comparador_sar_ctrl.sv
// Successive-approximation ADC controller: sequences the DAC trial code and captures the result.
// Optional macro COMPARADOR_SAR_CONT_EN adds cont_i for back-to-back conversions.
module comparador_sar_ctrl
    import comparador_sar_pkg::*;
#(
    parameter int N_BITS     = DEF_N_BITS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
`ifdef COMPARADOR_SAR_CONT_EN
    input  logic              cont_i,
`endif
    input  logic              cmp_i,
    output logic              sample_o,
    output logic [N_BITS-1:0] dac_code_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_BITS-1:0] result_o
);

    localparam int K_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
    localparam logic [K_W-1:0]    K_TOP    = K_W'(N_BITS - 1);
    localparam logic [N_BITS-1:0] MSB_CODE = N_BITS'(1) << (N_BITS - 1);

    // With no settle time the controller goes straight from a code update to DECIDE.
    localparam sar_state_e AFTER_CODE = (SETTLE_CYC > 0) ? ST_SETTLE : ST_DECIDE;

    sar_state_e        state_q, state_d;
    logic [N_BITS-1:0] code_q, code_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_BITS-1:0] decided;
    logic [K_W-1:0]    k_m1;
    logic              cont_req;

`ifdef COMPARADOR_SAR_CONT_EN
    assign cont_req = cont_i;
`else
    assign cont_req = 1'b0;
`endif

    assign k_m1 = k_q - K_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            result_q <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            result_q <= result_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_d = AFTER_CODE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                state_d = (k_q == '0) ? ST_DONE : AFTER_CODE;
            end
            ST_DONE: begin
                state_d = cont_req ? ST_SAMPLE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Trial-code datapath: keep or drop bit k on the comparator, then try bit k-1.
    always_comb begin
        decided = code_q;
        if (!cmp_i) begin
            decided[k_q] = 1'b0;
        end
        if (k_q != '0) begin
            decided[k_m1] = 1'b1;
        end
    end

    always_comb begin
        code_d   = code_q;
        result_d = result_q;
        k_d      = k_q;
        cnt_d    = cnt_q;

        if (state_d == ST_SETTLE && state_q != ST_SETTLE) begin
            cnt_d = CNT_LOAD;
        end else if (state_q == ST_SETTLE && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (state_d == ST_SAMPLE && state_q != ST_SAMPLE) begin
            code_d = MSB_CODE;
            k_d    = K_TOP;
        end else if (state_q == ST_DECIDE) begin
            code_d = decided;
            if (k_q != '0) begin
                k_d = k_m1;
            end else begin
                result_d = decided;
            end
        end else if (state_q == ST_DONE && state_d == ST_IDLE) begin
            code_d = '0;
            k_d    = '0;
        end
    end

    always_comb begin
        sample_o   = (state_q == ST_SAMPLE);
        busy_o     = (state_q == ST_SAMPLE) || (state_q == ST_SETTLE) || (state_q == ST_DECIDE);
        done_o     = (state_q == ST_DONE);
        dac_code_o = code_q;
        result_o   = result_q;
    end

endmodule

// File: tb/tb_comparador_sar_ctrl.sv
// Self-checking bench for comparador_sar_ctrl: default instance plus a zero-settle instance,
// driven through an ideal-comparator behavioural model of binary search.
module tb_comparador_sar_ctrl;
    import comparador_sar_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start0;
    logic       cont;
    logic [7:0] vin_r;
    int         mode_r;
    int         sel_r;

    logic       cmp, sample, busy, done;
    logic [7:0] dac, result;
    logic       cmp0, sample0, busy0, done0;
    logic [7:0] dac0, result0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seq_q[$];
    logic [7:0] exp_trials[$];
    int         last_lat;
    logic [7:0] last_res;
    int         extra_samples;

    // mode 0: ideal comparator, 1: tied low, 2: tied high
    function automatic logic cmp_model(input int mode, input logic [7:0] v, input logic [7:0] code);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return (v >= code);
    endfunction

    function automatic logic [7:0] sar_model(input int mode, input logic [7:0] v);
        logic [7:0] acc;
        logic [7:0] trial;
        acc = 8'h00;
        exp_trials.delete();
        for (int k = 7; k >= 0; k--) begin
            trial = acc | (8'h01 << k);
            exp_trials.push_back(trial);
            if (cmp_model(mode, v, trial)) acc = trial;
        end
        return acc;
    endfunction

    assign cmp  = cmp_model(mode_r, vin_r, dac);
    assign cmp0 = cmp_model(mode_r, vin_r, dac0);

    comparador_sar_ctrl #(.N_BITS(8), .SETTLE_CYC(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
`ifdef COMPARADOR_SAR_CONT_EN
        .cont_i(cont),
`endif
        .cmp_i(cmp), .sample_o(sample), .dac_code_o(dac),
        .busy_o(busy), .done_o(done), .result_o(result)
    );

    comparador_sar_ctrl #(.N_BITS(8), .SETTLE_CYC(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0),
`ifdef COMPARADOR_SAR_CONT_EN
        .cont_i(1'b0),
`endif
        .cmp_i(cmp0), .sample_o(sample0), .dac_code_o(dac0),
        .busy_o(busy0), .done_o(done0), .result_o(result0)
    );

    logic       m_sample, m_busy, m_done;
    logic [7:0] m_dac, m_result;
    assign m_sample = (sel_r == 1) ? sample0 : sample;
    assign m_busy   = (sel_r == 1) ? busy0   : busy;
    assign m_done   = (sel_r == 1) ? done0   : done;
    assign m_dac    = (sel_r == 1) ? dac0    : dac;
    assign m_result = (sel_r == 1) ? result0 : result;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start (or holds it if hold=1), records the distinct busy-time DAC codes,
    // and measures rising edges from start capture until done_o is seen.
    task automatic run_conv(input int sel, input logic [7:0] vin, input int mode,
                            input bit hold, input string tag);
        sel_r  = sel;
        vin_r  = vin;
        mode_r = mode;
        seq_q.delete();
        @(negedge clk);
        if (sel == 1) start0 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        start0 = 1'b0;
        chk({tag, "_sample"}, {31'd0, m_sample}, 32'd1);
        seq_q.push_back(m_dac);
        last_lat      = -1;
        last_res      = 8'hxx;
        extra_samples = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (m_done) begin
                last_lat = n;
                last_res = m_result;
                break;
            end
            if (m_sample) extra_samples++;
            if (m_busy && m_dac !== seq_q[$]) seq_q.push_back(m_dac);
        end
        chk({tag, "_latency"}, last_lat, (sel == 1) ? sar_latency(8, 0) : sar_latency(8, 2));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, m_done}, 32'd0);
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_seq_len"}, seq_q.size(), exp_trials.size());
        for (int j = 0; j < exp_trials.size(); j++) begin
            chk({tag, "_seq"}, (j < seq_q.size()) ? {24'd0, seq_q[j]} : 32'hFFFF_FFFF,
                {24'd0, exp_trials[j]});
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] expv;
        int         t1;
        int         t2;
        int         n_done;

        rst = 1'b1; start = 1'b0; start0 = 1'b0; cont = 1'b0;
        vin_r = 8'h00; mode_r = 0; sel_r = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample", {31'd0, sample}, 0);
        chk("rst_busy",   {31'd0, busy},   0);
        chk("rst_done",   {31'd0, done},   0);
        chk("rst_dac",    {24'd0, dac},    0);
        chk("rst_result", {24'd0, result}, 0);
        chk("rst0_busy",  {31'd0, busy0},  0);
        chk("rst0_dac",   {24'd0, dac0},   0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        expv = sar_model(0, 8'hA5);
        run_conv(0, 8'hA5, 0, 1'b0, "a5");
        chk("a5_result", {24'd0, last_res}, 32'h0000_00A5);
        chk_seq("a5");
        chk("a5_dac_idle", {24'd0, dac}, 0);
        chk("a5_result_hold", {24'd0, result}, 32'h0000_00A5);

        expv = sar_model(1, 8'h00);
        run_conv(0, 8'h77, 1, 1'b0, "tie0");
        chk("tie0_result", {24'd0, last_res}, {24'd0, expv});
        chk("tie0_result_const", {24'd0, last_res}, 32'h0);
        chk_seq("tie0");

        expv = sar_model(2, 8'h00);
        run_conv(0, 8'h11, 2, 1'b0, "tie1");
        chk("tie1_result", {24'd0, last_res}, 32'h0000_00FF);
        chk_seq("tie1");

        for (int i = 0; i < 6; i++) begin
            v    = 8'($urandom_range(0, 255));
            expv = sar_model(0, v);
            run_conv(0, v, 0, 1'b0, "rnd");
            chk("rnd_result", {24'd0, last_res}, {24'd0, expv});
            chk("rnd_result_vin", {24'd0, last_res}, {24'd0, v});
            chk_seq("rnd");
        end

        // start held high: no queued or restarted conversion, IDLE cycle before next SAMPLE
        expv = sar_model(0, 8'h3A);
        run_conv(0, 8'h3A, 0, 1'b1, "hold");
        chk("hold_result", {24'd0, last_res}, {24'd0, expv});
        chk("hold_extra_samples", extra_samples, 0);
        chk("hold_idle_sample", {31'd0, sample}, 0);
        chk("hold_idle_busy",   {31'd0, busy},   0);
        @(posedge clk); #1;
        chk("hold_resample", {31'd0, sample}, 1);
        start = 1'b0;
        n_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("hold_second_done_count", n_done, 1);

        // reset during DECIDE with k=4
        sel_r = 0; vin_r = 8'hA5; mode_r = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("mid_dac_k4", {24'd0, dac}, 32'h0000_00B0);
        chk("mid_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_sample", {31'd0, sample}, 0);
        chk("mid_rst_busy",   {31'd0, busy},   0);
        chk("mid_rst_done",   {31'd0, done},   0);
        chk("mid_rst_dac",    {24'd0, dac},    0);
        chk("mid_rst_result", {24'd0, result}, 0);
        expv = sar_model(0, 8'h3C);
        run_conv(0, 8'h3C, 0, 1'b0, "post_rst");
        chk("post_rst_result", {24'd0, last_res}, 32'h0000_003C);
        chk_seq("post_rst");

        // zero settle cycles
        expv = sar_model(0, 8'h01);
        run_conv(1, 8'h01, 0, 1'b0, "s0");
        chk("s0_result", {24'd0, last_res}, 32'h0000_0001);
        chk_seq("s0");
        for (int i = 0; i < 3; i++) begin
            v    = 8'($urandom_range(0, 255));
            expv = sar_model(0, v);
            run_conv(1, v, 0, 1'b0, "s0_rnd");
            chk("s0_rnd_result", {24'd0, last_res}, {24'd0, expv});
        end

`ifdef COMPARADOR_SAR_CONT_EN
        sel_r = 0; vin_r = 8'h5A; mode_r = 0; cont = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        t1 = -1; t2 = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done && t1 < 0) begin
                t1 = n;
                chk("cont_res1", {24'd0, result}, 32'h0000_005A);
            end else if (done) begin
                t2 = n;
                chk("cont_res2", {24'd0, result}, 32'h0000_005A);
                break;
            end else if (t1 > 0 && n == t1 + 1) begin
                chk("cont_sample_after_done", {31'd0, sample}, 1);
            end
        end
        chk("cont_first_latency", t1, sar_latency(8, 2));
        chk("cont_gap", t2 - t1, 26);
        cont = 1'b0;
        repeat (40) @(posedge clk);
`else
        t1 = 0; t2 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comparador_sar_ctrl.md
COMPARADOR_SAR_CTRL -- requirements
Module: comparador_sar_ctrl

Interface
REQ-001 Parameter N_BITS, default 8: conversion resolution and DAC code width.
REQ-002 Parameter SETTLE_CYC, default 2: wait cycles after each DAC code update before sampling cmp_i; 0 is legal.
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  conversion request, sampled only in IDLE.
REQ-006 cmp_i  input  1  comparator decision: 1 when p_i >= n_i, i.e. input >= DAC level.
REQ-007 sample_o  output  1  sample/hold strobe, high only in SAMPLE.
REQ-008 dac_code_o  output  N_BITS  trial code driving the DAC that produces n_i.
REQ-009 busy_o  output  1  high in SAMPLE, SETTLE and DECIDE.
REQ-010 done_o  output  1  one-cycle pulse, high only in DONE.
REQ-011 result_o  output  N_BITS  final code, updated on entry to DONE and held until the next DONE or reset.

Function
REQ-012 FSM states SHALL be IDLE, SAMPLE, SETTLE, DECIDE, DONE.
REQ-013 IDLE -> SAMPLE when start_i=1; otherwise remain in IDLE; dac_code_o=0 in IDLE.
REQ-014 SAMPLE SHALL last one cycle, load dac_code_o = 1<<(N_BITS-1), load bit index k = N_BITS-1, then go to SETTLE (or to DECIDE if SETTLE_CYC=0).
REQ-015 SETTLE SHALL last exactly SETTLE_CYC cycles, counted by a down-counter reloaded on each entry, then go to DECIDE.
REQ-016 DECIDE SHALL last one cycle: bit k of dac_code_o is kept if cmp_i=1 and cleared if cmp_i=0; if k>0, set bit k-1, decrement k, and go to SETTLE/DECIDE per REQ-014; if k=0, go to DONE.
REQ-017 On entry to DONE, result_o SHALL be set to the final trial code including the bit-0 decision; DONE lasts one cycle and then returns to IDLE.
REQ-018 done_o SHALL be high in the cycle following the (1 + N_BITS*(SETTLE_CYC+1))th rising edge after the edge that sampled start_i (25 for the defaults).
REQ-019 start_i SHALL be ignored in SAMPLE, SETTLE, DECIDE and DONE; it is not queued.
REQ-020 cmp_i SHALL be sampled only in DECIDE; its value in other states has no effect.
REQ-021 dac_code_o SHALL change only on entry to SAMPLE, on DECIDE edges, and on return to IDLE.

Reset
REQ-022 rst_i=1 at a rising edge SHALL force IDLE and set sample_o=0, busy_o=0, done_o=0, dac_code_o=0, result_o=0, k=0 and the settle counter to 0, regardless of state.
REQ-023 A reset asserted mid-conversion SHALL discard partial results; the first start_i after reset deasserts SHALL begin a normal conversion.

Configuration
REQ-024 Macro COMPARADOR_SAR_CONT_EN defined: add input port cont_i (1 bit); if cont_i=1 in DONE, the next state is SAMPLE instead of IDLE, giving back-to-back conversions with no IDLE cycle.
REQ-025 Macro COMPARADOR_SAR_CONT_EN undefined: cont_i is absent and only single-shot conversions occur.

Structure
REQ-026 Package comparador_sar_pkg SHALL hold the state enum type, the default N_BITS and SETTLE_CYC constants, and the latency helper function used by the bench.
REQ-027 The block SHALL be a single module with no sub-module; the settle counter is inline.

Verification (N_BITS=8, SETTLE_CYC=2, bench comparator model cmp_i = vin >= dac_code_o)
REQ-028 vin=0xA5, start pulse -> dac_code_o sequence 80,C0,A0,B0,A8,A4,A6,A5; result_o=0xA5; done_o 25 edges after start.
REQ-029 cmp_i tied 0 -> result_o=0x00; cmp_i tied 1 -> result_o=0xFF; done_o is a single-cycle pulse in both cases.
REQ-030 start_i held high throughout a conversion -> exactly one done_o per conversion; a new SAMPLE occurs only after IDLE is re-entered.
REQ-031 rst_i pulsed while in DECIDE with k=4 -> all outputs are 0 on the next cycle; a following conversion with vin=0x3C gives result_o=0x3C.
REQ-032 SETTLE_CYC=0, vin=0x01 -> result_o=0x01 with done_o 9 edges after start.
REQ-033 COMPARADOR_SAR_CONT_EN defined, cont_i=1, vin=0x5A -> SAMPLE immediately follows each DONE, and successive done_o pulses are 26 cycles apart, each with result_o=0x5A.
